otter_mtimer: RTL and testbench

- RISC-V machine timer (mtime/mtimecmp) acting as a responder on the OTTER memory bus, alongside the SRAM. It answers CPU load/store requests to its register window.
- It holds a 64-bit free-running counter with a programmable prescaler and drives the machine timer interrupt to the CPU.
- The address decoder in the top level asserts bus_sel for the timer window; offsets below are relative to that window.

---
 rtl/otter_mtimer.sv | 164 ++++++++++++++++
 tb/tb_otter_mtimer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mtimer.sv
// RISC-V machine timer (64-bit mtime / mtimecmp with prescaler) answering OTTER bus accesses.
// A request is sampled in IDLE (writes land on that edge) and acknowledged for one cycle in RESP.
module otter_mtimer #(
  parameter int          ADDR_W      = 8,
  parameter int          PRESC_W     = 16,
  parameter int unsigned PRESC_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_be,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              bus_err,
  output logic              timer_irq,
  output logic              dbg_state_o
);

  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q, cmp_d;
  logic [31:0]        snap_q, snap_d;
  logic               en_q, en_d;
  logic               irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [WORD_W-1:0]  word;
  logic               sel_lo, sel_hi, sel_cmp_lo, sel_cmp_hi, sel_ctrl, sel_presc;
  logic               mapped;
  logic [31:0]        rd_val;
  logic               req, rd_only, tick;
  logic               unused_addr;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign word        = bus_addr[ADDR_W-1:2];
  assign unused_addr = ^bus_addr[1:0];

  // Handshake: the initiator raises bus_sel with bus_rd and/or bus_wr and holds them until it
  // sees bus_ack. IDLE samples the request; RESP shows bus_ack for exactly one cycle and ignores
  // whatever is on the bus, so a held request is never taken twice. One access per two cycles.
  assign req     = bus_sel & (bus_rd | bus_wr);
  assign rd_only = bus_rd & ~bus_wr;
  assign tick    = en_q & (pcnt_q == presc_q);

  always_comb begin
    sel_lo     = 1'b0;
    sel_hi     = 1'b0;
    sel_cmp_lo = 1'b0;
    sel_cmp_hi = 1'b0;
    sel_ctrl   = 1'b0;
    sel_presc  = 1'b0;
    rd_val     = '0;
    case (word)
      WORD_W'(0): begin sel_lo     = 1'b1; rd_val = mtime_q[31:0];              end
      WORD_W'(1): begin sel_hi     = 1'b1; rd_val = snap_q;                     end
      WORD_W'(2): begin sel_cmp_lo = 1'b1; rd_val = cmp_q[31:0];                end
      WORD_W'(3): begin sel_cmp_hi = 1'b1; rd_val = cmp_q[63:32];               end
      WORD_W'(4): begin sel_ctrl   = 1'b1; rd_val = {30'd0, irq_en_q, en_q};    end
      WORD_W'(5): begin sel_presc  = 1'b1; rd_val = 32'(presc_q);               end
      default: ;
    endcase
  end

  assign mapped = sel_lo | sel_hi | sel_cmp_lo | sel_cmp_hi | sel_ctrl | sel_presc;

  always_comb begin
    state_d  = state_q;
    mtime_d  = mtime_q + 64'(tick);
    cmp_d    = cmp_q;
    snap_d   = snap_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    irq_d    = irq_en_q & (mtime_q >= cmp_q);
    if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RESP;
          rdata_d = rd_only ? rd_val : 32'd0;
          err_d   = ~mapped;
          if (rd_only & sel_lo) snap_d = mtime_q[63:32];
          if (bus_wr) begin
            // A bus write to mtime replaces this edge's increment entirely.
            if (sel_lo)     mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], bus_wdata, bus_be)};
            if (sel_hi)     mtime_d = {merge_be(mtime_q[63:32], bus_wdata, bus_be), mtime_q[31:0]};
            if (sel_cmp_lo) cmp_d[31:0]  = merge_be(cmp_q[31:0], bus_wdata, bus_be);
            if (sel_cmp_hi) cmp_d[63:32] = merge_be(cmp_q[63:32], bus_wdata, bus_be);
            if (sel_ctrl && bus_be[0]) begin
              en_d     = bus_wdata[0];
              irq_en_d = bus_wdata[1];
            end
            if (sel_presc) begin
              presc_d = PRESC_W'(merge_be(32'(presc_q), bus_wdata, bus_be));
              pcnt_d  = '0;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mtime_q  <= '0;
      cmp_q    <= '1;
      snap_q   <= '0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      presc_q  <= PRESC_W'(PRESC_RESET);
      pcnt_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // A reset landing on the RESP cycle swallows the pending acknowledge.
  assign bus_ack     = (state_q == ST_RESP) & ~rst;
  assign bus_rdata   = bus_ack ? rdata_q : 32'd0;
  assign bus_err     = bus_ack & err_q;
  assign timer_irq   = irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_otter_mtimer.sv
// Self-checking bench for otter_mtimer: each scenario task drives the bus and checks inline
// against expectations derived from cycle arithmetic and a small register model.
module tb_otter_mtimer;

  localparam logic [7:0] OFF_LO     = 8'h00;
  localparam logic [7:0] OFF_HI     = 8'h04;
  localparam logic [7:0] OFF_CMP_LO = 8'h08;
  localparam logic [7:0] OFF_CMP_HI = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;
  localparam logic [7:0] OFF_PRESC  = 8'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_sel = 1'b0, bus_rd = 1'b0, bus_wr = 1'b0;
  logic [7:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack, bus_err, timer_irq, dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] exp_cmp [2];
  logic [31:0] exp_presc;

  otter_mtimer #(.ADDR_W(8), .PRESC_W(16), .PRESC_RESET(0)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .timer_irq(timer_irq), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "time limit reached");
  end

  // drivers
  task automatic bus_xfer(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int edge_no,
                          output int lat, output logic pulse_ok);
    int waited;
    @(negedge clk);
    bus_sel = 1'b1; bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = wdata; bus_be = be;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus_ack !== 1'b1 && waited < 8);
    n_cmp++;
    if (bus_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_timeout addr=%h: ack=%b after %0d cycles, required 1", addr, bus_ack, waited);
    end
    rdata = bus_rdata; err = bus_err; edge_no = cyc; lat = waited;
    bus_sel = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    @(negedge clk);
    pulse_ok = (bus_ack === 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] addr, output logic [31:0] d, output logic err,
                        output int e);
    int lat;
    logic pok;
    bus_xfer(1'b1, 1'b0, addr, 32'd0, 4'h0, d, err, e, lat, pok);
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output int e);
    int lat;
    logic pok;
    logic [31:0] d;
    logic err;
    bus_xfer(1'b0, 1'b1, addr, wd, be, d, err, e, lat, pok);
  endtask

  // scenarios
  task automatic test_reset();
    logic [31:0] v;
    logic er;
    int e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", bus_ack); end
    n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
    n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus_rdata); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus_err); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %b want 0", dbg_state); end
    rd_reg(OFF_CMP_LO, v, er, e);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_lo: got %h want ffffffff", v); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rst_cmp_lo_err: got %b want 0", er); end
    rd_reg(OFF_CMP_HI, v, er, e);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_hi: got %h want ffffffff", v); end
    rd_reg(OFF_CTRL, v, er, e);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL rst_ctrl: got %h want 1", v); end
    rd_reg(OFF_PRESC, v, er, e);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_presc: got %h want 0", v); end
    rd_reg(OFF_HI, v, er, e);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_snapshot: got %h want 0", v); end
  endtask

  task automatic test_count_rate();
    logic [31:0] v1, v2, d;
    logic er, pok;
    int w, a, b, lat;
    bus_xfer(1'b0, 1'b1, OFF_LO, 32'd0, 4'hF, d, er, w, lat, pok);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL wr_pulse: ack stayed high, want 1-cycle"); end
    bus_xfer(1'b1, 1'b0, OFF_LO, 32'd0, 4'h0, v1, er, a, lat, pok);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rd_latency: got %0d want 1", lat); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL rd_pulse: ack stayed high, want 1-cycle"); end
    n_cmp++; if (v1 !== 32'(a - 1 - w)) begin n_bad++; $display("FAIL count_first: got %0d want %0d", v1, a - 1 - w); end
    repeat (7) @(negedge clk);
    bus_xfer(1'b1, 1'b0, OFF_LO, 32'd0, 4'h0, v2, er, b, lat, pok);
    n_cmp++; if (v2 - v1 !== 32'(b - a)) begin n_bad++; $display("FAIL count_delta: got %0d want %0d", v2 - v1, b - a); end
  endtask

  task automatic test_prescale();
    logic [31:0] v1, v2;
    logic er;
    int p, r1, r2, e, exp_d;
    wr_reg(OFF_PRESC, 32'd3, 4'hF, p);
    rd_reg(OFF_LO, v1, er, r1);
    repeat (37) @(negedge clk);
    rd_reg(OFF_LO, v2, er, r2);
    exp_d = (r2 - 1 - p) / 4 - (r1 - 1 - p) / 4;
    n_cmp++; if (v2 - v1 !== 32'(exp_d)) begin n_bad++; $display("FAIL presc_delta: got %0d want %0d", v2 - v1, exp_d); end
    wr_reg(OFF_CTRL, 32'd0, 4'h1, e);
    rd_reg(OFF_LO, v1, er, r1);
    repeat (17) @(negedge clk);
    rd_reg(OFF_LO, v2, er, r2);
    n_cmp++; if (v2 !== v1) begin n_bad++; $display("FAIL en_hold: got %h want %h", v2, v1); end
    wr_reg(OFF_CTRL, 32'd1, 4'h1, e);
    wr_reg(OFF_PRESC, 32'd0, 4'hF, e);
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [63:0] exp64;
    logic er;
    int e, l, r;
    wr_reg(OFF_LO, 32'd0, 4'hF, e);
    wr_reg(OFF_HI, 32'd0, 4'hF, e);
    wr_reg(OFF_LO, 32'hFFFF_FFFE, 4'hF, l);
    repeat (4) @(negedge clk);
    rd_reg(OFF_LO, v, er, r);
    exp64 = 64'hFFFF_FFFE + 64'(r - 1 - l);
    n_cmp++; if (v !== exp64[31:0]) begin n_bad++; $display("FAIL wrap_lo: got %h want %h", v, exp64[31:0]); end
    rd_reg(OFF_HI, v, er, e);
    n_cmp++; if (v !== exp64[63:32]) begin n_bad++; $display("FAIL wrap_hi: got %h want %h", v, exp64[63:32]); end
    wr_reg(OFF_HI, 32'd5, 4'hF, e);
    rd_reg(OFF_HI, v, er, e);
    n_cmp++; if (v !== exp64[63:32]) begin n_bad++; $display("FAIL stale_snapshot: got %h want %h", v, exp64[63:32]); end
    rd_reg(OFF_LO, v, er, e);
    rd_reg(OFF_HI, v, er, e);
    n_cmp++; if (v !== 32'd5) begin n_bad++; $display("FAIL fresh_snapshot: got %h want 5", v); end
  endtask

  task automatic test_irq();
    int e, c, w;
    logic exp_irq;
    wr_reg(OFF_CTRL, 32'd0, 4'h1, e);
    wr_reg(OFF_HI, 32'd0, 4'hF, e);
    wr_reg(OFF_LO, 32'h1E, 4'hF, e);
    wr_reg(OFF_CMP_HI, 32'd0, 4'hF, e);
    wr_reg(OFF_CMP_LO, 32'h20, 4'hF, e);
    wr_reg(OFF_PRESC, 32'd0, 4'hF, e);
    wr_reg(OFF_CTRL, 32'd3, 4'h1, c);
    for (int i = 0; i < 6; i++) begin
      exp_irq = ((32'h1E + (cyc - 1 - c)) >= 32'h20);
      n_cmp++;
      if (timer_irq !== exp_irq) begin
        n_bad++; $display("FAIL irq_rise cyc+%0d: got %b want %b", cyc - c, timer_irq, exp_irq);
      end
      @(negedge clk);
    end
    wr_reg(OFF_CMP_HI, 32'd1, 4'hF, w);
    n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", timer_irq); end
    exp_cmp[0] = 32'h20;
    exp_cmp[1] = 32'h1;
  endtask

  task automatic test_byte_enable();
    logic [31:0] v, wd, d;
    logic [3:0] be;
    logic [7:0] addr;
    logic er, both, pok;
    int e, lat, idx;
    wr_reg(OFF_CMP_LO, 32'hFFFF_FFFF, 4'hF, e);
    wr_reg(OFF_CMP_LO, 32'hAABB_CCDD, 4'b0101, e);
    rd_reg(OFF_CMP_LO, v, er, e);
    n_cmp++; if (v !== 32'hFFBB_FFDD) begin n_bad++; $display("FAIL be_cmp_lo: got %h want ffbbffdd", v); end
    exp_cmp[0] = 32'hFFBB_FFDD;
    exp_presc = 32'd0;
    for (int k = 0; k < 10; k++) begin
      idx  = $urandom_range(0, 2);
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      both = 1'($urandom_range(0, 1));
      addr = (idx == 0) ? OFF_CMP_LO : (idx == 1) ? OFF_CMP_HI : OFF_PRESC;
      bus_xfer(both, 1'b1, addr, wd, be, d, er, e, lat, pok);
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be_err addr=%h: got %b want 0", addr, er); end
      if (both) begin
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rdwr_rdata addr=%h: got %h want 0", addr, d); end
      end
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (idx == 2) exp_presc[8*i +: 8] = wd[8*i +: 8];
          else exp_cmp[idx][8*i +: 8] = wd[8*i +: 8];
        end
      end
      exp_presc = exp_presc & 32'h0000_FFFF;
      rd_reg(addr, v, er, e);
      n_cmp++;
      if (v !== ((idx == 2) ? exp_presc : exp_cmp[idx])) begin
        n_bad++; $display("FAIL be_readback addr=%h be=%b: got %h want %h", addr, be, v,
                          (idx == 2) ? exp_presc : exp_cmp[idx]);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] v, d;
    logic [7:0] addr;
    logic er, pok;
    int e, lat, mode;
    rd_reg(8'h18, v, er, e);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL unmapped_18_err: got %b want 1", er); end
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL unmapped_18_rdata: got %h want 0", v); end
    for (int k = 0; k < 6; k++) begin
      addr = {6'($urandom_range(6, 63)), 2'($urandom_range(0, 3))};
      mode = $urandom_range(0, 2);
      bus_xfer(mode != 1, mode != 0, addr, $urandom, 4'hF, d, er, e, lat, pok);
      n_cmp++; if (er !== 1'b1 || d !== 32'd0) begin
        n_bad++; $display("FAIL unmapped addr=%h: err=%b rdata=%h want err=1 rdata=0", addr, er, d);
      end
    end
    rd_reg(OFF_CMP_LO, v, er, e);
    n_cmp++; if (v !== exp_cmp[0]) begin n_bad++; $display("FAIL unmapped_side_effect: got %h want %h", v, exp_cmp[0]); end
  endtask

  task automatic test_random_mtime();
    logic [31:0] v, lo, hi;
    logic er;
    int e, p, m, r, per, ticks;
    wr_reg(OFF_CTRL, 32'd1, 4'h1, e);
    for (int k = 0; k < 5; k++) begin
      per = $urandom_range(1, 6);
      lo  = $urandom_range(0, 32'hFFF0_0000);
      hi  = $urandom;
      wr_reg(OFF_PRESC, 32'(per - 1), 4'hF, p);
      wr_reg(OFF_LO, 32'd0, 4'hF, e);
      wr_reg(OFF_HI, hi, 4'hF, e);
      wr_reg(OFF_LO, lo, 4'hF, m);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      rd_reg(OFF_LO, v, er, r);
      ticks = (r - 1 - p) / per - (m - p) / per;
      n_cmp++; if (v !== lo + 32'(ticks)) begin
        n_bad++; $display("FAIL rand_lo presc=%0d: got %h want %h", per - 1, v, lo + 32'(ticks));
      end
      rd_reg(OFF_HI, v, er, e);
      n_cmp++; if (v !== hi) begin n_bad++; $display("FAIL rand_hi: got %h want %h", v, hi); end
    end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] v;
    logic er;
    int e;
    @(negedge clk);
    bus_sel = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = OFF_CTRL; bus_be = 4'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL rst_in_resp_ack: got %b want 0", bus_ack); end
    bus_sel = 1'b0; bus_rd = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL rst_in_resp_late_ack: got %b want 0", bus_ack); end
    end
    rd_reg(OFF_PRESC, v, er, e);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL rst_in_resp_presc: got %h want 0", v); end
    rd_reg(OFF_CMP_LO, v, er, e);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_in_resp_cmp: got %h want ffffffff", v); end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_count_rate();
    test_prescale();
    test_wrap();
    test_irq();
    test_byte_enable();
    test_unmapped();
    test_random_mtime();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
